flash_read_sequencer: RTL and testbench
=======================================

Name: flash_read_sequencer

Overview:
- Command sequencer that sits directly upstream of the byte-level SPI master driving the W25Q32 flash.
- Accepts a read request (24-bit address, byte count) and issues the standard READ command (0x03) followed by the 3 address bytes.
- Clocks out the requested number of data bytes one SPI byte at a time.
- Delivers the data bytes on a valid/ready stream to the consumer (boot loader / memory copier).

Parameters:
- LEN_W, 16, width of the request byte count.
- READ_CMD, 8'h03, opcode sent as the first byte.
- CS_GAP, 4, minimum clock cycles spi_active stays low between transactions (flash tSHSL); legal range 1 to 255.

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept a request.
- req_addr  input  24  flash byte address.
- req_len  input  LEN_W  number of data bytes to read.
- data_out  output  8  read byte.
- data_valid  output  1  data_out valid.
- data_ready  input  1  consumer accepts data_out.
- done  output  1  one-cycle pulse when a request completes.
- spi_active  output  1  to SPI master: transaction active (/CS low while high).
- spi_send  output  1  to SPI master: one-cycle pulse to start an 8-bit transfer.
- spi_out  output  8  to SPI master: byte to transmit, stable from spi_send until that byte completes.
- spi_sending  input  1  from SPI master: high while a byte transfer is in progress.
- spi_in  input  8  from SPI master: received byte, valid in the cycle spi_sending is first seen low after a transfer.

Behaviour:
- Reset values:
  - req_ready=0, data_valid=0, done=0, spi_active=0, spi_send=0, spi_out=0, data_out=0.
  - State goes to GAP with the gap counter loaded to CS_GAP; req_ready rises once the gap has elapsed.
- Reset asserted mid-operation:
  - spi_active drops on the next edge.
  - Any pending data_valid is withdrawn.
  - No done pulse is produced.
- States: IDLE, CMD, ADDR, DATA, HOLD, GAP.
- Byte sub-handshake, used in CMD, ADDR and DATA:
  - ISSUE: spi_send=1 for exactly one cycle.
  - WAIT_HI: wait until spi_sending=1.
  - WAIT_LO: wait until spi_sending=0; the byte is complete in that cycle.
  - spi_send is never asserted while spi_sending=1.
- IDLE:
  - req_ready=1; request accepted when req_valid & req_ready.
  - Address and length are latched on acceptance.
  - req_len=0: done pulses the next cycle, then go to GAP; spi_active is never raised.
  - Otherwise: spi_active=1, spi_out=READ_CMD and spi_send=1 in the cycle after acceptance; go to CMD.
- CMD:
  - On byte completion, go to ADDR with spi_out=addr[23:16].
- ADDR:
  - Three bytes in order: addr[23:16], addr[15:8], addr[7:0].
  - Each spi_send is issued in the cycle after the previous byte completes.
  - After the third byte, go to DATA with spi_out=8'h00 (dummy transmit).
- DATA:
  - On byte completion, data_out<=spi_in, data_valid<=1, remaining count decremented; go to HOLD.
- HOLD:
  - data_out and data_valid are held stable until data_ready.
  - On the handshake cycle:
    - If remaining≠0: data_valid=0 and the next spi_send is issued the following cycle (back to DATA).
    - If remaining=0: data_valid=0, spi_active=0, done=1 for one cycle; go to GAP.
  - No SPI transfer is started while a byte is unconsumed; at most one byte is buffered.
- GAP:
  - spi_active=0 and req_ready=0 for CS_GAP cycles, then IDLE.
- Other rules:
  - req_valid while not in IDLE is ignored; the request is not latched.
  - spi_active stays high continuously from the CMD byte through the last data byte, including during HOLD stalls.
  - Length counting is modulo 2^LEN_W; the maximum request is 2^LEN_W−1 bytes.
  - The address is not incremented by this block; the flash auto-increments internally.
  - Address wrap at the flash end is the flash's behaviour, not checked here.

Test Plan:
- Single-byte read: req_addr=24'h123456, req_len=1; SPI model returns 8'hA5 on the 5th byte -> spi_out sequence 03,12,34,56,00; exactly 5 spi_send pulses; data_out=A5 with data_valid; done one cycle after handshake; spi_active low thereafter.
- Backpressure: req_len=3, model returns 11,22,33; data_ready held low 10 cycles on byte 2 -> no spi_send during the stall; spi_active stays high; stream is 11,22,33; done pulses once.
- Zero length: req_len=0 -> spi_active never rises; done pulses the cycle after acceptance; req_ready returns after CS_GAP cycles.
- Reset mid-DATA: assert reset after the 2nd data byte of a req_len=8 request -> spi_active=0 and data_valid=0 on the next edge; no done; a new request (addr 0, len 1) then completes normally.
- Back-to-back requests: two requests with req_valid held high -> spi_active low for ≥CS_GAP (4) cycles between transactions; req_ready low throughout the first transaction; second request's address is correct.
- Slow SPI model: spi_sending rises 3 cycles after spi_send and lasts 16 cycles -> no duplicate spi_send; spi_out stable for each whole byte.

Source files
------------

// File: rtl/flash_read_sequencer.sv
// Flash read sequencer: sends READ + 24-bit address through a byte-level SPI master,
// then streams the requested data bytes out on a valid/ready interface.
module flash_read_sequencer #(
  parameter int         LEN_W    = 16,
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         CS_GAP   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             done,
  output logic             spi_active,
  output logic             spi_send,
  output logic [7:0]       spi_out,
  input  logic             spi_sending,
  input  logic [7:0]       spi_in
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, GAP} state_t;
  typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO} phase_t;

  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP);

  state_t           state_q;
  phase_t           phase_q;
  logic [7:0]       gap_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       addr_idx_q;
  logic             req_ready_q;
  logic             data_valid_q;
  logic             done_q;
  logic             spi_active_q;
  logic             spi_send_q;
  logic [7:0]       data_out_q;
  logic [7:0]       spi_out_q;

  logic in_byte;
  logic byte_done;

  assign in_byte   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  // The received byte is only valid in the first cycle the master drops spi_sending.
  assign byte_done = in_byte && (phase_q == WAIT_LO) && !spi_sending;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= GAP;
      phase_q      <= ISSUE;
      gap_q        <= GAP_LOAD;
      addr_q       <= '0;
      rem_q        <= '0;
      addr_idx_q   <= '0;
      req_ready_q  <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      spi_active_q <= 1'b0;
      spi_send_q   <= 1'b0;
      data_out_q   <= '0;
      spi_out_q    <= '0;
    end else begin
      spi_send_q <= 1'b0;
      done_q     <= 1'b0;

      if (in_byte) begin
        case (phase_q)
          ISSUE:   phase_q <= WAIT_HI;
          WAIT_HI: if (spi_sending) phase_q <= WAIT_LO;
          default: ;
        endcase
      end

      case (state_q)
        GAP: begin
          if (gap_q <= 8'd1) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end

        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
            rem_q       <= req_len;
            if (req_len == '0) begin
              done_q  <= 1'b1;
              state_q <= GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              spi_active_q <= 1'b1;
              spi_out_q    <= READ_CMD;
              spi_send_q   <= 1'b1;
              phase_q      <= ISSUE;
              state_q      <= CMD;
            end
          end
        end

        CMD: begin
          if (byte_done) begin
            state_q    <= ADDR;
            addr_idx_q <= 2'd0;
            spi_out_q  <= addr_q[23:16];
            spi_send_q <= 1'b1;
            phase_q    <= ISSUE;
          end
        end

        ADDR: begin
          if (byte_done) begin
            spi_send_q <= 1'b1;
            phase_q    <= ISSUE;
            case (addr_idx_q)
              2'd0: begin
                spi_out_q  <= addr_q[15:8];
                addr_idx_q <= 2'd1;
              end
              2'd1: begin
                spi_out_q  <= addr_q[7:0];
                addr_idx_q <= 2'd2;
              end
              default: begin
                spi_out_q <= 8'h00;
                state_q   <= DATA;
              end
            endcase
          end
        end

        DATA: begin
          if (byte_done) begin
            data_out_q   <= spi_in;
            data_valid_q <= 1'b1;
            rem_q        <= rem_q - LEN_W'(1);
            state_q      <= HOLD;
          end
        end

        HOLD: begin
          // Next transfer only starts once the buffered byte is taken.
          if (data_ready) begin
            data_valid_q <= 1'b0;
            if (rem_q != '0) begin
              state_q    <= DATA;
              spi_send_q <= 1'b1;
              phase_q    <= ISSUE;
            end else begin
              spi_active_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= GAP;
              gap_q        <= GAP_LOAD;
            end
          end
        end

        default: begin
          state_q <= GAP;
          gap_q   <= GAP_LOAD;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign spi_active = spi_active_q;
  assign spi_send   = spi_send_q;
  assign spi_out    = spi_out_q;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Bench for flash_read_sequencer: SPI byte-master model plus a transaction-level
// model of expected SPI bytes, data stream, done and handshake timing.
module tb_flash_read_sequencer;
  localparam int LEN_W  = 16;
  localparam int CS_GAP = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready = 1'b1;
  logic             done;
  logic             spi_active;
  logic             spi_send;
  logic [7:0]       spi_out;
  logic             spi_sending = 1'b0;
  logic [7:0]       spi_in = '0;

  flash_read_sequencer #(.LEN_W(LEN_W), .READ_CMD(8'h03), .CS_GAP(CS_GAP)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .done(done),
    .spi_active(spi_active), .spi_send(spi_send), .spi_out(spi_out),
    .spi_sending(spi_sending), .spi_in(spi_in)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string name, input logic [7:0] got[$], input logic [7:0] want[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(want[i]));
  endtask

  // model state
  logic [7:0] exp_spi[$];
  logic [7:0] exp_data[$];
  logic [7:0] got_data[$];
  logic [7:0] spi_log[$];
  logic [7:0] resp_tab[16];
  bit         exp_active = 0, exp_valid = 0, exp_done = 0, exp_ready = 0;
  int         gap_n = 0;
  int         done_cnt = 0;
  int         sends = 0;
  int         spi_dly = 1, spi_dur = 4;
  int         m = 0, mcnt = 0, bidx = 0;
  logic [7:0] latched = '0;
  logic [3:0] k4;
  int         low_run = 0, last_low_run = 0;
  bit         prev_active = 0;

  initial begin
    forever begin
      @(negedge clock);
      chk("spi_active", 32'(spi_active), 32'(exp_active));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("done", 32'(done), 32'(exp_done));
      chk("data_valid", 32'(data_valid), 32'(exp_valid));
      if (data_valid && exp_valid) begin
        if (exp_data.size() == 0) chk("data_extra", 32'(1), 32'(0));
        else chk("data_out", 32'(data_out), 32'(exp_data[0]));
      end
      if (done) done_cnt++;
      if (spi_send) begin
        chk("send_while_busy", 32'({spi_sending, m != 0, data_valid}), 32'(0));
        if (exp_spi.size() == 0) chk("spi_unexpected", 32'(1), 32'(0));
        else chk("spi_out", 32'(spi_out), 32'(exp_spi.pop_front()));
        spi_log.push_back(spi_out);
        sends++;
      end
      if (m != 0) chk("spi_out_stable", 32'(spi_out), 32'(latched));
      if (spi_active) begin
        if (!prev_active) last_low_run = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_active = spi_active;

      // predict next cycle
      exp_done = 0;
      if (reset) begin
        exp_spi.delete();
        exp_data.delete();
        exp_active = 0;
        exp_valid  = 0;
        exp_ready  = 0;
        gap_n      = CS_GAP;
        m          = 0;
        spi_sending = 1'b0;
      end else begin
        if (exp_ready && req_valid) begin
          exp_ready = 0;
          bidx = 0;
          if (req_len == '0) begin
            exp_done = 1;
            gap_n = CS_GAP;
          end else begin
            exp_active = 1;
            exp_spi.push_back(8'h03);
            exp_spi.push_back(req_addr[23:16]);
            exp_spi.push_back(req_addr[15:8]);
            exp_spi.push_back(req_addr[7:0]);
            for (int k = 0; k < int'(req_len); k++) begin
              exp_spi.push_back(8'h00);
              exp_data.push_back(resp_tab[4'(k)]);
            end
          end
        end else if (exp_valid && data_ready) begin
          got_data.push_back(data_out);
          if (exp_data.size() != 0) void'(exp_data.pop_front());
          exp_valid = 0;
          if (exp_data.size() == 0) begin
            exp_done   = 1;
            exp_active = 0;
            gap_n      = CS_GAP;
          end
        end else if (gap_n > 0) begin
          gap_n--;
          if (gap_n == 0) exp_ready = 1;
        end

        // SPI byte master model
        case (m)
          0: if (spi_send) begin
            latched = spi_out;
            mcnt = spi_dly;
            m = 1;
          end
          1: begin
            mcnt--;
            if (mcnt == 0) begin
              spi_sending = 1'b1;
              mcnt = spi_dur;
              m = 2;
            end
          end
          default: begin
            mcnt--;
            if (mcnt == 0) begin
              spi_sending = 1'b0;
              m = 0;
              if (bidx >= 4) begin
                k4 = 4'(bidx - 4);
                spi_in = resp_tab[k4];
                exp_valid = 1;
              end else begin
                spi_in = 8'hEE;
              end
              bidx++;
            end
          end
        endcase
      end
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
    int i;
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = a; req_len = l;
    i = 0;
    @(negedge clock);
    while (!req_ready && i < 400) begin @(negedge clock); i++; end
    chk("req_accept", 32'(req_ready), 32'(1));
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clock);
    chk("done_seen", 32'(done_cnt >= target), 32'(1));
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_data.size() < n; i++) @(negedge clock);
    chk("got_count", 32'(got_data.size() >= n), 32'(1));
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !data_valid; i++) @(negedge clock);
    chk("valid_seen", 32'(data_valid), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, n;
    logic [7:0] want[$];
    for (int i = 0; i < 16; i++) resp_tab[i] = 8'(i * 17);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_spi_out", 32'(spi_out), 32'(0));
    chk("rst_spi_send", 32'(spi_send), 32'(0));

    // single byte read
    resp_tab[0] = 8'hA5;
    spi_log.delete(); got_data.delete(); d0 = done_cnt;
    do_req(24'h123456, 16'd1);
    wait_done(d0 + 1, 300);
    want = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00};
    chk_seq("t1_spi", spi_log, want);
    want = '{8'hA5};
    chk_seq("t1_data", got_data, want);
    repeat (2) @(negedge clock);
    chk("t1_cs_low", 32'(spi_active), 32'(0));

    // backpressure on byte 2
    resp_tab[0] = 8'h11; resp_tab[1] = 8'h22; resp_tab[2] = 8'h33;
    spi_log.delete(); got_data.delete(); d0 = done_cnt;
    do_req(24'h0ABCDE, 16'd3);
    wait_got(1, 300);
    @(posedge clock); #1 data_ready = 1'b0;
    wait_valid(300);
    s0 = sends;
    repeat (10) @(negedge clock);
    chk("t2_no_send_stall", 32'(sends), 32'(s0));
    chk("t2_cs_held", 32'(spi_active), 32'(1));
    @(posedge clock); #1 data_ready = 1'b1;
    wait_done(d0 + 1, 300);
    repeat (3) @(negedge clock);
    chk("t2_done_once", 32'(done_cnt), 32'(d0 + 1));
    want = '{8'h11, 8'h22, 8'h33};
    chk_seq("t2_data", got_data, want);

    // zero length
    spi_log.delete(); d0 = done_cnt;
    do_req(24'h000100, 16'd0);
    n = 0;
    while (n < 50) begin
      @(negedge clock); n++;
      if (req_ready) break;
    end
    // done cycle is the first of CS_GAP low-ready cycles
    chk("t3_ready_return", 32'(n), 32'(CS_GAP + 1));
    chk("t3_done", 32'(done_cnt), 32'(d0 + 1));
    chk("t3_no_spi", 32'(spi_log.size()), 32'(0));

    // reset while byte 2 is held
    for (int i = 0; i < 8; i++) resp_tab[i] = 8'(8'hC0 + i);
    got_data.delete();
    do_req(24'h00F00D, 16'd8);
    wait_got(1, 300);
    @(posedge clock); #1 data_ready = 1'b0;
    wait_valid(300);
    @(posedge clock); #1 reset = 1'b1;
    d0 = done_cnt;
    @(posedge clock); #1;
    chk("t4_cs_drop", 32'(spi_active), 32'(0));
    chk("t4_valid_drop", 32'(data_valid), 32'(0));
    reset = 1'b0; data_ready = 1'b1;
    repeat (20) @(negedge clock);
    chk("t4_no_done", 32'(done_cnt), 32'(d0));
    resp_tab[0] = 8'h5C;
    spi_log.delete(); got_data.delete(); d0 = done_cnt;
    do_req(24'h000000, 16'd1);
    wait_done(d0 + 1, 300);
    want = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_seq("t4_spi", spi_log, want);
    want = '{8'h5C};
    chk_seq("t4_data", got_data, want);

    // back-to-back with req_valid held
    resp_tab[0] = 8'h61; resp_tab[1] = 8'h62;
    spi_log.delete(); got_data.delete(); d0 = done_cnt;
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = 24'hAA0001; req_len = 16'd2;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 400) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    req_addr = 24'h55BEEF; req_len = 16'd1;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 600) begin @(negedge clock); n++; end
    chk("t5_second_ready", 32'(req_ready), 32'(1));
    @(posedge clock); #1 req_valid = 1'b0;
    wait_done(d0 + 2, 600);
    chk("t5_cs_gap_min", 32'(last_low_run >= CS_GAP), 32'(1));
    want = '{8'h03, 8'hAA, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h55, 8'hBE, 8'hEF, 8'h00};
    chk_seq("t5_spi", spi_log, want);
    want = '{8'h61, 8'h62, 8'h61};
    chk_seq("t5_data", got_data, want);

    // slow SPI master
    spi_dly = 3; spi_dur = 16;
    resp_tab[0] = 8'h9A; resp_tab[1] = 8'h9B;
    got_data.delete(); d0 = done_cnt; s0 = sends;
    do_req(24'h765432, 16'd2);
    wait_done(d0 + 1, 1000);
    chk("t6_send_count", 32'(sends - s0), 32'(6));
    want = '{8'h9A, 8'h9B};
    chk_seq("t6_data", got_data, want);

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
